ahb_interconnect_dec: RTL and testbench

//  Parametrised AHB3-Lite single-master decoder/response mux for the Hardisc platform bus.
//  - Sits between the core's AHB master port and N slaves.
//  - Decodes with base/mask pairs and lowest-index priority.
//  - Routes the data-phase response back to the master.
//  - Unmapped accesses go to an internal default slave that returns a two-cycle ERROR.
//  - Optional watchdog aborts hung slaves.

---
 rtl/ahb_interconnect_dec_if.sv | 45 ++++
 rtl/ahb_interconnect_dec.sv | 182 ++++++++++++++++++
 tb/tb_ahb_interconnect_dec.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_interconnect_dec_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_interconnect_dec_if
//  Purpose  : Bus bundle between the AHB master, the decoder and N slaves.
//             The slave modport is the decoder's view of the bundle.
//             The master modport is the view of whatever drives the bus and
//             the slave-side returns (core plus slave models).
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_interconnect_dec_if #(
   parameter int SLAVES = 2,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int CW     = 7
);
   logic [AW-1:0]              s_mhaddr_i;
   logic [1:0]                 s_mhtrans_i;
   logic [SLAVES-1:0][AW-1:0]  s_sbase_i;
   logic [SLAVES-1:0][AW-1:0]  s_smask_i;
   logic [SLAVES-1:0][DW-1:0]  s_shrdata_i;
   logic [SLAVES-1:0][CW-1:0]  s_shrchecksum_i;
   logic [SLAVES-1:0]          s_shready_i;
   logic [SLAVES-1:0]          s_shresp_i;
   logic [SLAVES-1:0]          s_hsel_o;
   logic [DW-1:0]              s_shrdata_o;
   logic [CW-1:0]              s_shrchecksum_o;
   logic                       s_shready_o;
   logic                       s_shresp_o;
   logic [SLAVES-1:0]          s_timeout_o;

   modport slave (
      input  s_mhaddr_i, s_mhtrans_i, s_sbase_i, s_smask_i,
             s_shrdata_i, s_shrchecksum_i, s_shready_i, s_shresp_i,
      output s_hsel_o, s_shrdata_o, s_shrchecksum_o, s_shready_o,
             s_shresp_o, s_timeout_o
   );

   modport master (
      output s_mhaddr_i, s_mhtrans_i, s_sbase_i, s_smask_i,
             s_shrdata_i, s_shrchecksum_i, s_shready_i, s_shresp_i,
      input  s_hsel_o, s_shrdata_o, s_shrchecksum_o, s_shready_o,
             s_shresp_o, s_timeout_o
   );
endinterface
`default_nettype wire

// File: rtl/ahb_interconnect_dec.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_interconnect_dec
//  Purpose  : AHB3-Lite single-master address decoder and response mux.
//             Base/mask decode with lowest-index priority. Unmapped
//             accesses hit an internal default slave that answers with a
//             two-cycle ERROR.
//             Optional watchdog (macro AHB_ICN_TIMEOUT_EN) aborts a slave
//             that stalls for TMO_CYCLES cycles and blacklists it until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_interconnect_dec #(
   parameter int SLAVES     = 2,
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int CW         = 7,
   parameter int TMO_CYCLES = 256
) (
   input wire                     s_clk_i,
   input wire                     s_resetn_i,
   ahb_interconnect_dec_if.slave  bus
);
   // Select index space: 0..SLAVES-1 are real slaves, SLAVES is the default slave.
   localparam int              SW          = $clog2(SLAVES + 1);
   localparam logic [SW-1:0]   DEFAULT_SEL = SW'(SLAVES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } err_state_t;

   err_state_t        state_q, state_d;
   logic              active_q, active_d;
   logic [SW-1:0]     dsel_q, dsel_d;
   logic              err_ready_q, err_ready_d;
   logic              err_resp_q, err_resp_d;
   logic [SLAVES-1:0] flag_q;

`ifdef AHB_ICN_TIMEOUT_EN
   localparam int     CNTW = $clog2(TMO_CYCLES);
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [SLAVES-1:0] flag_d;
   logic              stall;
   logic              abort;
`else
   assign flag_q = '0;
`endif

   logic              active;
   logic [SW-1:0]     dec_idx;
   logic              dec_blocked;
   logic              sel_ready;
   logic              sel_resp;
   logic [DW-1:0]     sel_rdata;
   logic [CW-1:0]     sel_cs;
   logic              hready;
   logic              hresp;
   logic [DW-1:0]     hrdata;
   logic [CW-1:0]     hcs;
   logic              take_def;

   assign active = bus.s_mhtrans_i[1];

   // Address decode: the lowest matching window wins; a blacklisted winner falls to default.
   always_comb begin
      dec_idx     = DEFAULT_SEL;
      dec_blocked = 1'b0;
      for (int i = SLAVES - 1; i >= 0; i--) begin
         if ((bus.s_mhaddr_i & bus.s_smask_i[i]) == bus.s_sbase_i[i]) begin
            dec_idx     = SW'(i);
            dec_blocked = flag_q[i];
         end
      end
      if (dec_blocked) begin
         dec_idx = DEFAULT_SEL;
      end
   end

   generate
      for (genvar g = 0; g < SLAVES; g++) begin : g_hsel
         assign bus.s_hsel_o[g] = active && (dec_idx == SW'(g));
      end
   endgenerate

   // Pick the data-phase slave's response lines.
   always_comb begin
      sel_ready = 1'b1;
      sel_resp  = 1'b0;
      sel_rdata = '0;
      sel_cs    = '0;
      for (int i = 0; i < SLAVES; i++) begin
         if (dsel_q == SW'(i)) begin
            sel_ready = bus.s_shready_i[i];
            sel_resp  = bus.s_shresp_i[i];
            sel_rdata = bus.s_shrdata_i[i];
            sel_cs    = bus.s_shrchecksum_i[i];
         end
      end
   end

   // Response mux back to the master: idle, real slave or default-slave FSM.
   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      hcs    = '0;
      if (active_q) begin
         if (dsel_q == DEFAULT_SEL) begin
            hready = err_ready_q;
            hresp  = err_resp_q;
         end else begin
            hready = sel_ready;
            hresp  = sel_resp;
            hrdata = sel_rdata;
            hcs    = sel_cs;
         end
      end
   end

   assign bus.s_shready_o     = hready;
   assign bus.s_shresp_o      = hresp;
   assign bus.s_shrdata_o     = hrdata;
   assign bus.s_shrchecksum_o = hcs;
   assign bus.s_timeout_o     = flag_q;

   // Next-state: data-phase capture, error FSM and the optional watchdog override.
   always_comb begin
      take_def = hready && active && (dec_idx == DEFAULT_SEL);
      active_d = hready ? active  : active_q;
      dsel_d   = hready ? dec_idx : dsel_q;
      state_d  = state_q;
      case (state_q)
         ST_IDLE: if (take_def) state_d = ST_ERR1;
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = take_def ? ST_ERR1 : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
`ifdef AHB_ICN_TIMEOUT_EN
      stall  = active_q && (dsel_q != DEFAULT_SEL) && !sel_ready;
      abort  = stall && (cnt_q == CNTW'(TMO_CYCLES - 1));
      cnt_d  = (stall && !abort) ? cnt_q + 1'b1 : '0;
      flag_d = flag_q;
      if (abort) begin
         for (int i = 0; i < SLAVES; i++) begin
            if (dsel_q == SW'(i)) flag_d[i] = 1'b1;
         end
         // Hand the stuck data phase to the default slave so the slave is ignored from now on.
         state_d = ST_ERR1;
         dsel_d  = DEFAULT_SEL;
      end
`endif
      err_ready_d = (state_d != ST_ERR1);
      err_resp_d  = (state_d != ST_IDLE);
   end

   // State registers, including registered error-FSM outputs.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q     <= ST_IDLE;
         active_q    <= 1'b0;
         dsel_q      <= '0;
         err_ready_q <= 1'b1;
         err_resp_q  <= 1'b0;
`ifdef AHB_ICN_TIMEOUT_EN
         cnt_q       <= '0;
         flag_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         dsel_q      <= dsel_d;
         err_ready_q <= err_ready_d;
         err_resp_q  <= err_resp_d;
`ifdef AHB_ICN_TIMEOUT_EN
         cnt_q       <= cnt_d;
         flag_q      <= flag_d;
`endif
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ahb_interconnect_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_interconnect_dec
//  Purpose  : Self-checking bench for ahb_interconnect_dec (directed
//             scenarios plus a randomized run against a transaction model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_interconnect_dec;
   localparam int SLAVES = 2;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int CW     = 7;
   localparam int TMO    = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ahb_interconnect_dec_if #(.SLAVES(SLAVES), .AW(AW), .DW(DW), .CW(CW)) bus();

   ahb_interconnect_dec #(
      .SLAVES(SLAVES), .AW(AW), .DW(DW), .CW(CW), .TMO_CYCLES(TMO)
   ) dut (
      .s_clk_i   (clk),
      .s_resetn_i(rst_n),
      .bus       (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] map_base [SLAVES];
   logic [31:0] map_mask [SLAVES];

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] t);
      bus.s_mhaddr_i  = a;
      bus.s_mhtrans_i = t;
   endtask

   task automatic set_slave(input int k, input logic rdy, input logic rsp,
                            input logic [31:0] d, input logic [6:0] cs);
      bus.s_shready_i[k]     = rdy;
      bus.s_shresp_i[k]      = rsp;
      bus.s_shrdata_i[k]     = d;
      bus.s_shrchecksum_i[k] = cs;
   endtask

   task automatic apply_maps();
      for (int i = 0; i < SLAVES; i++) begin
         bus.s_sbase_i[i] = map_base[i];
         bus.s_smask_i[i] = map_mask[i];
      end
   endtask

   task automatic default_maps();
      map_base[0] = 32'h0000_0000; map_mask[0] = 32'hFFFF_0000;
      map_base[1] = 32'h0001_0000; map_mask[1] = 32'hFFFF_0000;
      apply_maps();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(32'h0, 2'd0);
      for (int k = 0; k < SLAVES; k++) set_slave(k, 1'b1, 1'b0, 32'h0, 7'h0);
      step();
      rst_n = 1'b1;
   endtask

   // Reference decode from the address map: lowest matching window, -1 if unmapped.
   function automatic int ref_decode(input logic [31:0] a);
      for (int i = 0; i < SLAVES; i++)
         if ((a & map_mask[i]) == map_base[i]) return i;
      return -1;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      default_maps();
      drive(32'h0, 2'd0);
      for (int k = 0; k < SLAVES; k++) set_slave(k, 1'b1, 1'b0, 32'h1234_5678, 7'h55);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++; if (bus.s_shready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.s_shready_o); else n_pass++;
      n_total++; if (bus.s_shresp_o !== 1'b0) $display("FAIL reset_resp: got %b want 0", bus.s_shresp_o); else n_pass++;
      n_total++; if (bus.s_hsel_o !== 2'b00) $display("FAIL reset_hsel: got %b want 00", bus.s_hsel_o); else n_pass++;
      n_total++; if (bus.s_shrdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.s_shrdata_o); else n_pass++;
      n_total++; if (bus.s_shrchecksum_o !== 7'h0) $display("FAIL reset_checksum: got %h want 0", bus.s_shrchecksum_o); else n_pass++;
      n_total++; if (bus.s_timeout_o !== 2'b00) $display("FAIL reset_timeout: got %b want 00", bus.s_timeout_o); else n_pass++;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_decode_route();
      default_maps();
      drive(32'h0001_0004, 2'd2);
      set_slave(1, 1'b1, 1'b0, 32'hDEAD_BEEF, 7'h2A);
      @(negedge clk);
      n_total++; if (bus.s_hsel_o !== 2'b10) $display("FAIL route_hsel: got %b want 10", bus.s_hsel_o); else n_pass++;
      step();
      drive(32'h0, 2'd0);
      @(negedge clk);
      n_total++; if (bus.s_shrdata_o !== 32'hDEAD_BEEF) $display("FAIL route_rdata: got %h want deadbeef", bus.s_shrdata_o); else n_pass++;
      n_total++; if (bus.s_shrchecksum_o !== 7'h2A) $display("FAIL route_checksum: got %h want 2a", bus.s_shrchecksum_o); else n_pass++;
      n_total++; if (bus.s_shresp_o !== 1'b0) $display("FAIL route_resp: got %b want 0", bus.s_shresp_o); else n_pass++;
      n_total++; if (bus.s_hsel_o !== 2'b00) $display("FAIL route_idle_hsel: got %b want 00", bus.s_hsel_o); else n_pass++;
      step();
   endtask

   task automatic test_overlap();
      map_base[1] = 32'h0000_0000; map_mask[1] = 32'hFFFF_0000;
      apply_maps();
      drive(32'h0000_0010, 2'd2);
      set_slave(0, 1'b1, 1'b0, 32'h1111_0000, 7'h11);
      set_slave(1, 1'b1, 1'b0, 32'h2222_0000, 7'h22);
      @(negedge clk);
      n_total++; if (bus.s_hsel_o !== 2'b01) $display("FAIL overlap_hsel: got %b want 01", bus.s_hsel_o); else n_pass++;
      step();
      drive(32'h0, 2'd0);
      @(negedge clk);
      n_total++; if (bus.s_shrdata_o !== 32'h1111_0000) $display("FAIL overlap_rdata: got %h want 11110000", bus.s_shrdata_o); else n_pass++;
      step();
      default_maps();
   endtask

   task automatic test_unmapped();
      drive(32'h8000_0000, 2'd2);
      set_slave(0, 1'b1, 1'b0, 32'h0BAD_F00D, 7'h33);
      @(negedge clk);
      n_total++; if (bus.s_hsel_o !== 2'b00) $display("FAIL unmapped_hsel: got %b want 00", bus.s_hsel_o); else n_pass++;
      step();
      drive(32'h0000_0008, 2'd3);
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b01) $display("FAIL err1_ready_resp: got %b want 01", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      n_total++; if (bus.s_hsel_o !== 2'b01) $display("FAIL err1_hsel: got %b want 01", bus.s_hsel_o); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b11) $display("FAIL err2_ready_resp: got %b want 11", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      n_total++; if (bus.s_shrdata_o !== 32'h0) $display("FAIL err2_rdata: got %h want 0", bus.s_shrdata_o); else n_pass++;
      step();
      drive(32'h0, 2'd0);
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b10) $display("FAIL seq_after_err: got %b want 10", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      n_total++; if (bus.s_shrdata_o !== 32'h0BAD_F00D) $display("FAIL seq_after_err_rdata: got %h want 0badf00d", bus.s_shrdata_o); else n_pass++;
      step();
      // two unmapped accesses back to back
      drive(32'h9000_0000, 2'd2);
      step();
      drive(32'hA000_0000, 2'd2);
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b01) $display("FAIL b2b_first_err1: got %b want 01", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b11) $display("FAIL b2b_first_err2: got %b want 11", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
      drive(32'h0, 2'd0);
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b01) $display("FAIL b2b_second_err1: got %b want 01", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b11) $display("FAIL b2b_second_err2: got %b want 11", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b10) $display("FAIL b2b_back_idle: got %b want 10", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
   endtask

   task automatic test_stall();
      drive(32'h0000_0000, 2'd2);
      set_slave(0, 1'b1, 1'b0, 32'h0, 7'h0);
      step();
      drive(32'h0001_0000, 2'd2);
      set_slave(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 7'h7F);
      set_slave(1, 1'b1, 1'b0, 32'h5151_5151, 7'h51);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_total++; if (bus.s_shready_o !== 1'b0) $display("FAIL stall_ready_c%0d: got %b want 0", c, bus.s_shready_o); else n_pass++;
         n_total++; if (bus.s_hsel_o !== 2'b10) $display("FAIL stall_hsel_c%0d: got %b want 10", c, bus.s_hsel_o); else n_pass++;
         step();
      end
      set_slave(0, 1'b1, 1'b0, 32'hA0A0_A0A0, 7'h0A);
      @(negedge clk);
      n_total++; if (bus.s_shready_o !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", bus.s_shready_o); else n_pass++;
      n_total++; if (bus.s_shrdata_o !== 32'hA0A0_A0A0) $display("FAIL stall_release_rdata: got %h want a0a0a0a0", bus.s_shrdata_o); else n_pass++;
      step();
      drive(32'h0, 2'd0);
      @(negedge clk);
      n_total++; if (bus.s_shrdata_o !== 32'h5151_5151) $display("FAIL stall_next_rdata: got %h want 51515151", bus.s_shrdata_o); else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      drive(32'hC000_0000, 2'd2);
      step();
      drive(32'h0, 2'd0);
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b01) $display("FAIL mid_pre_err1: got %b want 01", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b10) $display("FAIL mid_reset_async: got %b want 10", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b10) $display("FAIL mid_after_reset: got %b want 10", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
   endtask

`ifdef AHB_ICN_TIMEOUT_EN
   task automatic test_timeout();
      pulse_reset();
      set_slave(1, 1'b0, 1'b0, 32'h7777_7777, 7'h77);
      drive(32'h0001_0000, 2'd2);
      step();
      drive(32'h0, 2'd0);
      for (int c = 0; c < TMO; c++) begin
         @(negedge clk);
         n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b00) $display("FAIL tmo_stall_c%0d: got %b want 00", c, {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
         step();
      end
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b01) $display("FAIL tmo_err1: got %b want 01", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      n_total++; if (bus.s_timeout_o !== 2'b10) $display("FAIL tmo_flag: got %b want 10", bus.s_timeout_o); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b11) $display("FAIL tmo_err2: got %b want 11", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
      set_slave(1, 1'b1, 1'b0, 32'h7777_7777, 7'h77);
      drive(32'h0001_0020, 2'd2);
      @(negedge clk);
      n_total++; if (bus.s_hsel_o !== 2'b00) $display("FAIL tmo_blocked_hsel: got %b want 00", bus.s_hsel_o); else n_pass++;
      step();
      drive(32'h0, 2'd0);
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b01) $display("FAIL tmo_blocked_err1: got %b want 01", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if ({bus.s_shready_o, bus.s_shresp_o} !== 2'b11) $display("FAIL tmo_blocked_err2: got %b want 11", {bus.s_shready_o, bus.s_shresp_o}); else n_pass++;
      n_total++; if (bus.s_timeout_o !== 2'b10) $display("FAIL tmo_flag_sticky: got %b want 10", bus.s_timeout_o); else n_pass++;
      step();
   endtask
`else
   task automatic test_no_timeout();
      pulse_reset();
      set_slave(1, 1'b0, 1'b0, 32'h0, 7'h0);
      drive(32'h0001_0000, 2'd2);
      step();
      drive(32'h0, 2'd0);
      repeat (TMO + 3) step();
      @(negedge clk);
      n_total++; if (bus.s_shready_o !== 1'b0) $display("FAIL notmo_still_stalled: got %b want 0", bus.s_shready_o); else n_pass++;
      n_total++; if (bus.s_shresp_o !== 1'b0) $display("FAIL notmo_resp: got %b want 0", bus.s_shresp_o); else n_pass++;
      n_total++; if (bus.s_timeout_o !== 2'b00) $display("FAIL notmo_flag: got %b want 00", bus.s_timeout_o); else n_pass++;
      set_slave(1, 1'b1, 1'b0, 32'h0, 7'h0);
      step();
   endtask
`endif

   // Randomized traffic against a transaction-level model of the data phase.
   task automatic test_random();
      int          kind;      // 0: no data phase, 1: real slave, 2: default-slave error
      int          tgt_k;
      int          err_cyc;
      int          run [SLAVES];
      int          tgt;
      int          region;
      bit          hold;
      logic [31:0] addr;
      logic [1:0]  tr;
      logic [1:0]  exp_hsel;
      logic        exp_rdy;
      logic        exp_rsp;
      logic [31:0] exp_data;
      logic [6:0]  exp_cs;
      int          errs_before;
      errs_before = n_total - n_pass;
      default_maps();
      pulse_reset();
      kind = 0; tgt_k = 0; err_cyc = 0; hold = 1'b0; addr = 32'h0; tr = 2'd0;
      for (int k = 0; k < SLAVES; k++) run[k] = 0;
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            region = $urandom_range(0, 2);
            case (region)
               0:       addr = {16'h0000, 16'($urandom)};
               1:       addr = {16'h0001, 16'($urandom)};
               default: addr = 32'h8000_0000 | 32'($urandom);
            endcase
            tr = 2'($urandom_range(0, 3));
         end
         for (int k = 0; k < SLAVES; k++) begin
            if (run[k] >= 2 || $urandom_range(0, 3) != 0) begin
               bus.s_shready_i[k] = 1'b1;
               run[k] = 0;
            end else begin
               bus.s_shready_i[k] = 1'b0;
               run[k]++;
            end
            bus.s_shresp_i[k]      = ($urandom_range(0, 7) == 0);
            bus.s_shrdata_i[k]     = $urandom;
            bus.s_shrchecksum_i[k] = 7'($urandom);
         end
         drive(addr, tr);
         @(negedge clk);
         tgt      = ref_decode(addr);
         exp_hsel = (tr[1] && tgt >= 0) ? 2'(1 << tgt) : 2'b00;
         exp_rdy  = 1'b1; exp_rsp = 1'b0; exp_data = 32'h0; exp_cs = 7'h0;
         if (kind == 1) begin
            exp_rdy  = bus.s_shready_i[tgt_k];
            exp_rsp  = bus.s_shresp_i[tgt_k];
            exp_data = bus.s_shrdata_i[tgt_k];
            exp_cs   = bus.s_shrchecksum_i[tgt_k];
         end else if (kind == 2) begin
            exp_rdy = (err_cyc == 2);
            exp_rsp = 1'b1;
         end
         n_total++; if (bus.s_hsel_o !== exp_hsel) $display("FAIL rnd_hsel c%0d: got %b want %b", c, bus.s_hsel_o, exp_hsel); else n_pass++;
         n_total++; if (bus.s_shready_o !== exp_rdy) $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.s_shready_o, exp_rdy); else n_pass++;
         n_total++; if (bus.s_shresp_o !== exp_rsp) $display("FAIL rnd_resp c%0d: got %b want %b", c, bus.s_shresp_o, exp_rsp); else n_pass++;
         n_total++; if (bus.s_shrdata_o !== exp_data) $display("FAIL rnd_rdata c%0d: got %h want %h", c, bus.s_shrdata_o, exp_data); else n_pass++;
         n_total++; if (bus.s_shrchecksum_o !== exp_cs) $display("FAIL rnd_checksum c%0d: got %h want %h", c, bus.s_shrchecksum_o, exp_cs); else n_pass++;
         if (exp_rdy) begin
            hold = 1'b0;
            if (tr[1]) begin
               if (tgt < 0) begin kind = 2; err_cyc = 1; end
               else begin kind = 1; tgt_k = tgt; end
            end else begin
               kind = 0;
            end
         end else begin
            hold = 1'b1;
            if (kind == 2) err_cyc = 2;
         end
         if ((n_total - n_pass) - errs_before > 20) begin
            $display("FAIL rnd_abort: too many errors at cycle %0d", c);
            break;
         end
         step();
      end
      drive(32'h0, 2'd0);
      for (int k = 0; k < SLAVES; k++) set_slave(k, 1'b1, 1'b0, 32'h0, 7'h0);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_decode_route();
      test_overlap();
      test_unmapped();
      test_stall();
      test_reset_mid();
      test_random();
`ifdef AHB_ICN_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
